// File: rtl/spart_bus_if.sv
// Processor-side bus interface for the SPART serial port: address decode, tri-state
// read drive, RX/TX FIFOs, sticky RX overflow flag and atomic 16-bit baud divisor.
module spart_bus_if #(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd325
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  inout  wire  [DATA_W-1:0] databus,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [15:0]       baud_div,
  output logic              baud_load
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  logic [DATA_W-1:0] rx_mem_r [FIFO_DEPTH];
  logic [DATA_W-1:0] tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]     rx_wr_ptr_r, rx_rd_ptr_r, tx_wr_ptr_r, tx_rd_ptr_r;
  logic [CW-1:0]     rx_cnt_r, tx_cnt_r;
  logic              rx_ovf_r;
  logic [7:0]        low_shadow_r;
  logic [15:0]       baud_div_r;
  logic              baud_load_r;

  logic              rd_acc_s, wr_acc_s;
  logic              rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
  logic              rx_push_s, rx_pop_s, rx_ovf_evt_s, stat_rd_s;
  logic              tx_push_s, tx_pop_s;
  logic [7:0]        rx_cnt_ext_s;
  logic [3:0]        rx_cnt_sat_s;
  logic [7:0]        status_s;
  logic [DATA_W-1:0] read_data_s;

  assign rd_acc_s   = iocs & iorw;
  assign wr_acc_s   = iocs & ~iorw;
  assign rx_full_s  = (rx_cnt_r == FULL_CNT);
  assign rx_empty_s = (rx_cnt_r == CNT_ZERO);
  assign tx_full_s  = (tx_cnt_r == FULL_CNT);
  assign tx_empty_s = (tx_cnt_r == CNT_ZERO);

  // A pop by a data read frees a slot in the same cycle, so a full RX FIFO still accepts.
  assign rx_pop_s     = rd_acc_s & (ioaddr == 2'b00) & ~rx_empty_s;
  assign rx_push_s    = rx_valid & (~rx_full_s | rx_pop_s);
  assign rx_ovf_evt_s = rx_valid & rx_full_s & ~rx_pop_s;
  assign stat_rd_s    = rd_acc_s & (ioaddr == 2'b01);
  assign tx_push_s    = wr_acc_s & (ioaddr == 2'b00) & ~tx_full_s;
  assign tx_pop_s     = ~tx_empty_s & tx_ready;

  assign rx_cnt_ext_s = 8'(rx_cnt_r);
  assign rx_cnt_sat_s = (rx_cnt_ext_s > 8'd15) ? 4'hF : rx_cnt_ext_s[3:0];
  assign status_s     = {rx_cnt_sat_s, tx_empty_s, rx_ovf_r, ~tx_full_s, ~rx_empty_s};

  // Combinational read mux, selected by address.
  always_comb begin
    read_data_s = {DATA_W{1'b0}};
    case (ioaddr)
      2'b00: begin
        if (!rx_empty_s) read_data_s = rx_mem_r[rx_rd_ptr_r];
        else             read_data_s = {DATA_W{1'b0}};
      end
      2'b01:   read_data_s[7:0] = status_s;
      2'b10:   read_data_s[7:0] = baud_div_r[7:0];
      2'b11:   read_data_s[7:0] = baud_div_r[15:8];
      default: read_data_s = {DATA_W{1'b0}};
    endcase
  end

  assign databus = rd_acc_s ? read_data_s : {DATA_W{1'bz}};

  // FIFO storage; left unreset, contents are masked by the counts.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
    if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= databus;
  end

  // RX FIFO pointers, count and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_r <= PTR_ZERO;
      rx_rd_ptr_r <= PTR_ZERO;
      rx_cnt_r    <= CNT_ZERO;
      rx_ovf_r    <= 1'b0;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + CNT_ONE;
        2'b01:   rx_cnt_r <= rx_cnt_r - CNT_ONE;
        default: rx_cnt_r <= rx_cnt_r;
      endcase
      // A new overflow wins over the clear-on-read of the status register.
      if (rx_ovf_evt_s)   rx_ovf_r <= 1'b1;
      else if (stat_rd_s) rx_ovf_r <= 1'b0;
    end
  end

  // TX FIFO pointers and count; full is judged before the same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_r <= PTR_ZERO;
      tx_rd_ptr_r <= PTR_ZERO;
      tx_cnt_r    <= CNT_ZERO;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + CNT_ONE;
        2'b01:   tx_cnt_r <= tx_cnt_r - CNT_ONE;
        default: tx_cnt_r <= tx_cnt_r;
      endcase
    end
  end

  // Baud divisor: low byte staged in a shadow, committed together with the high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_shadow_r <= 8'd0;
      baud_div_r   <= DIV_RESET;
      baud_load_r  <= 1'b0;
    end else begin
      baud_load_r <= 1'b0;
      if (wr_acc_s && (ioaddr == 2'b10)) low_shadow_r <= databus[7:0];
      if (wr_acc_s && (ioaddr == 2'b11)) begin
        baud_div_r  <= {databus[7:0], low_shadow_r};
        baud_load_r <= 1'b1;
      end
    end
  end

  assign tx_valid  = ~tx_empty_s;
  assign tx_data   = tx_empty_s ? {DATA_W{1'b0}} : tx_mem_r[tx_rd_ptr_r];
  assign baud_div  = baud_div_r;
  assign baud_load = baud_load_r;

endmodule

// File: tb/tb_spart_bus_if.sv
// Directed self-checking bench for spart_bus_if (DATA_W=8, FIFO_DEPTH=8).
module tb_spart_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic [7:0]  bus_drv;
  logic        bus_oe;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic        baud_load;

  int total = 0;
  int bad   = 0;
  logic [7:0] rd_val;

  assign databus = bus_oe ? bus_drv : 8'bz;

  spart_bus_if #(.DATA_W(8), .FIFO_DEPTH(8), .DIV_RESET(16'd325)) dut (
    .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .baud_div(baud_div), .baud_load(baud_load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00; bus_oe = 1'b0; bus_drv = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; bus_drv = d; bus_oe = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    tick();
    bus_idle();
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_baud_div", 32'(baud_div), 32'd325);
    check("rst_baud_load", 32'(baud_load), 32'd0);
    rd(2'b01, rd_val); check("rst_status", 32'(rd_val), 32'h0A);

    // TX basic
    wr(2'b00, 8'h41); wr(2'b00, 8'h42);
    check("tx_valid1", 32'(tx_valid), 32'd1);
    check("tx_head1", 32'(tx_data), 32'h41);
    tx_ready = 1'b1; tick();
    check("tx_head2", 32'(tx_data), 32'h42);
    check("tx_valid2", 32'(tx_valid), 32'd1);
    tick(); tx_ready = 1'b0;
    check("tx_valid_empty", 32'(tx_valid), 32'd0);
    rd(2'b01, rd_val); check("tx_status_empty", 32'(rd_val), 32'h0A);

    // TX full: 9 writes, last dropped
    for (int i = 0; i < 8; i++) wr(2'b00, 8'(8'h10 + i));
    rd(2'b01, rd_val); check("tx_full_status", 32'(rd_val), 32'h00);
    wr(2'b00, 8'h18);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_drain_valid", 32'(tx_valid), 32'd1);
      check("tx_drain_data", 32'(tx_data), 32'(8'h10 + i));
      tick();
    end
    tx_ready = 1'b0;
    check("tx_drain_done", 32'(tx_valid), 32'd0);

    // RX overflow with one byte parked in TX
    wr(2'b00, 8'h99);
    for (int i = 1; i <= 9; i++) rx_push(8'(i));
    rd(2'b01, rd_val); check("rx_ovf_status", 32'(rd_val), 32'h87);
    rd(2'b01, rd_val); check("rx_ovf_cleared", 32'(rd_val), 32'h83);
    for (int i = 1; i <= 8; i++) begin
      rd(2'b00, rd_val); check("rx_data", 32'(rd_val), 32'(i));
    end
    rd(2'b00, rd_val); check("rx_empty_read", 32'(rd_val), 32'h00);
    rd(2'b01, rd_val); check("rx_drained_status", 32'(rd_val), 32'h02);
    check("tx_parked", 32'(tx_data), 32'h99);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("tx_parked_gone", 32'(tx_valid), 32'd0);

    // RX full with simultaneous pop and push
    for (int i = 0; i < 8; i++) rx_push(8'(8'h21 + i));
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; rx_valid = 1'b1; rx_data = 8'h55;
    #1 check("rx_simul_head", 32'(databus), 32'h21);
    tick();
    rx_valid = 1'b0; bus_idle();
    rd(2'b01, rd_val); check("rx_simul_status", 32'(rd_val), 32'h8B);
    for (int i = 1; i < 8; i++) begin
      rd(2'b00, rd_val); check("rx_simul_data", 32'(rd_val), 32'(8'h21 + i));
    end
    rd(2'b00, rd_val); check("rx_simul_last", 32'(rd_val), 32'h55);
    rd(2'b00, rd_val); check("rx_simul_empty", 32'(rd_val), 32'h00);
    wr(2'b01, 8'hFF);
    rd(2'b01, rd_val); check("status_wr_ignored", 32'(rd_val), 32'h0A);

    // Baud divisor
    wr(2'b10, 8'h34);
    check("baud_low_only", 32'(baud_div), 32'd325);
    check("baud_load_low", 32'(baud_load), 32'd0);
    wr(2'b11, 8'h12);
    check("baud_div_new", 32'(baud_div), 32'h1234);
    check("baud_load_pulse", 32'(baud_load), 32'd1);
    tick();
    check("baud_load_end", 32'(baud_load), 32'd0);
    rd(2'b10, rd_val); check("baud_rd_lo", 32'(rd_val), 32'h34);
    rd(2'b11, rd_val); check("baud_rd_hi", 32'(rd_val), 32'h12);

    // Async reset mid-access with 3 entries in each FIFO
    for (int i = 0; i < 3; i++) rx_push(8'(8'hA0 + i));
    for (int i = 0; i < 3; i++) wr(2'b00, 8'(8'hB0 + i));
    rd(2'b01, rd_val); check("pre_rst_status", 32'(rd_val), 32'h33);
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; bus_drv = 8'h77; bus_oe = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_baud", 32'(baud_div), 32'd325);
    bus_idle();
    @(negedge clk); rst_n = 1'b1;
    tick();
    rd(2'b01, rd_val); check("post_rst_status", 32'(rd_val), 32'h0A);
    rd(2'b00, rd_val); check("post_rst_rx_empty", 32'(rd_val), 32'h00);
    check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b01; bus_drv = 8'h50; bus_oe = 1'b1;
    #1 check("bus_released", 32'(databus), 32'h50);
    bus_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
